// File: rtl/rv32i_hazard_unit.sv
// RV32I hazard, forwarding and flush controller: a shift-register scoreboard of in-flight
// destination tags from EXEC to WB drives stalls, flushes, forwarding selects and perf counters.
module rv32i_hazard_unit #(
    parameter int NB_STAGES = 3,
    parameter bit FWD_EN    = 1'b1,
    parameter int CNT_W     = 32,
    parameter int SEL_W     = $clog2(NB_STAGES + 1)
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             imem_valid_i,
    input  logic [31:0]      dec_instr_i,
    input  logic             dec_valid_i,
    input  logic             alu_zero_i,
    input  logic             alu_lt_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             branch_taken_o,
    output logic [SEL_W-1:0] fwd_rs1_sel_o,
    output logic [SEL_W-1:0] fwd_rs2_sel_o,
    output logic [4:0]       wb_rd_o,
    output logic             wb_we_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       is_load;
        logic [4:0] rd;
        logic [6:0] opcode;
        logic [2:0] funct3;
    } sb_entry_t;

    sb_entry_t sb_q [NB_STAGES:1];
    sb_entry_t sb_d [NB_STAGES:1];
    sb_entry_t dec_rec;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] dec_opcode;
    logic [4:0] dec_rs1, dec_rs2;
    logic       uses_rs1, uses_rs2, writes_rd, is_load;
    logic [NB_STAGES:1] hit_rs1, hit_rs2;
    logic [SEL_W-1:0]   sel_rs1, sel_rs2;
    logic       raw_any, load_use, branch_taken, flush, stall;
    logic       unused_funct7;

    assign dec_opcode    = dec_instr_i[6:0];
    assign dec_rs1       = dec_instr_i[19:15];
    assign dec_rs2       = dec_instr_i[24:20];
    assign unused_funct7 = ^dec_instr_i[31:25];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (dec_opcode)
            OP_R:             begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OP_IMM, OP_JALR:  begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_LOAD:          begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; end
            OP_STORE, OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            default: ;
        endcase
        if (!dec_valid_i) begin
            uses_rs1  = 1'b0;
            uses_rs2  = 1'b0;
            writes_rd = 1'b0;
            is_load   = 1'b0;
        end
    end

    always_comb begin
        hit_rs1 = '0;
        hit_rs2 = '0;
        for (int k = 1; k <= NB_STAGES; k++) begin
            hit_rs1[k] = uses_rs1 && (dec_rs1 != 5'd0) && sb_q[k].valid && sb_q[k].wr
                         && (sb_q[k].rd == dec_rs1);
            hit_rs2[k] = uses_rs2 && (dec_rs2 != 5'd0) && sb_q[k].valid && sb_q[k].wr
                         && (sb_q[k].rd == dec_rs2);
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites the select last.
    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        for (int k = NB_STAGES; k >= 1; k--) begin
            if (hit_rs1[k]) sel_rs1 = SEL_W'(k);
            if (hit_rs2[k]) sel_rs2 = SEL_W'(k);
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        if (sb_q[1].valid && (sb_q[1].opcode == OP_BRANCH)) begin
            case (sb_q[1].funct3)
                3'b000:         branch_taken = alu_zero_i;
                3'b001:         branch_taken = !alu_zero_i;
                3'b100, 3'b110: branch_taken = alu_lt_i;
                3'b101, 3'b111: branch_taken = !alu_lt_i;
                default:        branch_taken = 1'b0;
            endcase
        end
    end

    assign raw_any  = (|hit_rs1) | (|hit_rs2);
    assign load_use = (hit_rs1[1] | hit_rs2[1]) & sb_q[1].is_load;
    assign flush    = branch_taken | (sb_q[1].valid &
                      ((sb_q[1].opcode == OP_JAL) | (sb_q[1].opcode == OP_JALR)));
    // A flush discards the DECODE instruction, so any hazard it carries is moot.
    assign stall    = (FWD_EN ? load_use : raw_any) & ~flush;

    always_comb begin
        dec_rec = '0;
        if (dec_valid_i) begin
            dec_rec.valid   = 1'b1;
            dec_rec.wr      = writes_rd;
            dec_rec.is_load = is_load;
            dec_rec.rd      = dec_instr_i[11:7];
            dec_rec.opcode  = dec_opcode;
            dec_rec.funct3  = dec_instr_i[14:12];
        end
    end

    always_comb begin
        sb_d = sb_q;
        if (imem_valid_i) begin
            for (int k = NB_STAGES; k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[1] = (stall || flush) ? '0 : dec_rec;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (imem_valid_i && stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (imem_valid_i && flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int k = 1; k <= NB_STAGES; k++) begin
                sb_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_o        = stall;
    assign flush_o        = flush;
    assign branch_taken_o = branch_taken;
    assign fwd_rs1_sel_o  = FWD_EN ? sel_rs1 : '0;
    assign fwd_rs2_sel_o  = FWD_EN ? sel_rs2 : '0;
    assign wb_rd_o        = sb_q[NB_STAGES].rd;
    assign wb_we_o        = sb_q[NB_STAGES].valid & sb_q[NB_STAGES].wr & (sb_q[NB_STAGES].rd != 5'd0);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Bench for rv32i_hazard_unit: a forwarding instance (4-bit counters) and a non-forwarding
// instance share one instruction stream; each is compared against its own pipeline model.
module tb_rv32i_hazard_unit;

    localparam int NB = 3;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_valid = 1'b1;
    logic [31:0] dec_instr = '0;
    logic        dec_valid = 1'b0;
    logic        alu_zero = 1'b0;
    logic        alu_lt = 1'b0;

    logic        f_stall, f_flush, f_bt, f_wbwe;
    logic [1:0]  f_sel1, f_sel2;
    logic [4:0]  f_wbrd;
    logic [3:0]  f_scnt, f_fcnt;
    logic        n_stall, n_flush, n_bt, n_wbwe;
    logic [1:0]  n_sel1, n_sel2;
    logic [4:0]  n_wbrd;
    logic [31:0] n_scnt, n_fcnt;

    int n_pass = 0;
    int n_total = 0;

    typedef struct packed {
        bit       v;
        bit       wr;
        bit       ld;
        bit [4:0] rd;
        bit [6:0] op;
        bit [2:0] f3;
    } ent_t;

    ent_t   pipe [0:1][1:NB];
    longint scnt [0:1];
    longint fcnt [0:1];
    bit     e_stall [0:1];
    bit     e_flush [0:1];
    bit     e_bt [0:1];
    bit     e_wbwe [0:1];
    int     e_sel1 [0:1];
    int     e_sel2 [0:1];
    int     e_wbrd [0:1];
    longint e_scnt [0:1];
    longint e_fcnt [0:1];

    rv32i_hazard_unit #(.NB_STAGES(NB), .FWD_EN(1'b1), .CNT_W(4)) dut_f (
        .clk_i(clk), .resetn_i(resetn), .imem_valid_i(imem_valid),
        .dec_instr_i(dec_instr), .dec_valid_i(dec_valid),
        .alu_zero_i(alu_zero), .alu_lt_i(alu_lt),
        .stall_o(f_stall), .flush_o(f_flush), .branch_taken_o(f_bt),
        .fwd_rs1_sel_o(f_sel1), .fwd_rs2_sel_o(f_sel2),
        .wb_rd_o(f_wbrd), .wb_we_o(f_wbwe),
        .stall_cnt_o(f_scnt), .flush_cnt_o(f_fcnt)
    );

    rv32i_hazard_unit #(.NB_STAGES(NB), .FWD_EN(1'b0), .CNT_W(32)) dut_n (
        .clk_i(clk), .resetn_i(resetn), .imem_valid_i(imem_valid),
        .dec_instr_i(dec_instr), .dec_valid_i(dec_valid),
        .alu_zero_i(alu_zero), .alu_lt_i(alu_lt),
        .stall_o(n_stall), .flush_o(n_flush), .branch_taken_o(n_bt),
        .fwd_rs1_sel_o(n_sel1), .fwd_rs2_sel_o(n_sel2),
        .wb_rd_o(n_wbrd), .wb_we_o(n_wbwe),
        .stall_cnt_o(n_scnt), .flush_cnt_o(n_fcnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int f3,
                                        input int rs1, input int rs2);
        return {7'd0, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic longint cmax(input int m);
        return (m == 0) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int k = 1; k <= NB; k++) pipe[m][k] = '0;
            scnt[m] = 0;
            fcnt[m] = 0;
        end
    endtask

    // Present one DECODE cycle, derive this cycle's expected outputs, then step the model.
    task automatic drive(input logic [31:0] ins, input bit v, input bit z, input bit l, input bit iv);
        bit u1, u2, wr, ld, lu, any, bt, fl, st;
        bit [6:0] op;
        bit [4:0] rs1, rs2;
        int s1, s2;
        ent_t e, rec;
        @(negedge clk);
        dec_instr = ins; dec_valid = v; alu_zero = z; alu_lt = l; imem_valid = iv;
        #1;
        op  = ins[6:0];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        u1 = v && (op inside {OP_R, OP_IMM, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH});
        u2 = v && (op inside {OP_R, OP_STORE, OP_BRANCH});
        wr = v && (op inside {OP_R, OP_IMM, OP_JALR, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL});
        ld = v && (op == OP_LOAD);
        for (int m = 0; m < 2; m++) begin
            s1 = 0; s2 = 0; lu = 0; any = 0;
            for (int k = 1; k <= NB; k++) begin
                e = pipe[m][k];
                if (e.v && e.wr && u1 && rs1 != 0 && e.rd == rs1) begin
                    any = 1; if (s1 == 0) s1 = k; if (k == 1 && e.ld) lu = 1;
                end
                if (e.v && e.wr && u2 && rs2 != 0 && e.rd == rs2) begin
                    any = 1; if (s2 == 0) s2 = k; if (k == 1 && e.ld) lu = 1;
                end
            end
            e = pipe[m][1];
            bt = 0;
            if (e.v && e.op == OP_BRANCH) begin
                case (e.f3)
                    0: bt = z;
                    1: bt = !z;
                    4, 6: bt = l;
                    5, 7: bt = !l;
                    default: bt = 0;
                endcase
            end
            fl = bt || (e.v && (e.op == OP_JAL || e.op == OP_JALR));
            st = ((m == 0) ? lu : any) && !fl;
            if (m == 1) begin s1 = 0; s2 = 0; end
            e_stall[m] = st; e_flush[m] = fl; e_bt[m] = bt;
            e_sel1[m] = s1; e_sel2[m] = s2;
            e_wbrd[m] = pipe[m][NB].rd;
            e_wbwe[m] = pipe[m][NB].v && pipe[m][NB].wr && pipe[m][NB].rd != 0;
            e_scnt[m] = scnt[m]; e_fcnt[m] = fcnt[m];
            if (iv) begin
                for (int k = NB; k >= 2; k--) pipe[m][k] = pipe[m][k-1];
                rec = '0;
                if (v && !st && !fl) begin
                    rec.v = 1; rec.wr = wr; rec.ld = ld;
                    rec.rd = ins[11:7]; rec.op = op; rec.f3 = ins[14:12];
                end
                pipe[m][1] = rec;
                if (st && scnt[m] < cmax(m)) scnt[m]++;
                if (fl && fcnt[m] < cmax(m)) fcnt[m]++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        dec_valid = 0; dec_instr = '0; imem_valid = 1; alu_zero = 0; alu_lt = 0;
        resetn = 0;
        model_clear();
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_reset();
        resetn = 0;
        model_clear();
        @(negedge clk); #1;
        n_total++; if (f_stall !== 1'b0) $display("[TB] FAIL reset_f_stall got=%b exp=0", f_stall); else n_pass++;
        n_total++; if (f_flush !== 1'b0) $display("[TB] FAIL reset_f_flush got=%b exp=0", f_flush); else n_pass++;
        n_total++; if (f_bt !== 1'b0) $display("[TB] FAIL reset_f_bt got=%b exp=0", f_bt); else n_pass++;
        n_total++; if (f_sel1 !== 2'd0 || f_sel2 !== 2'd0) $display("[TB] FAIL reset_f_sel got=%0d/%0d exp=0/0", f_sel1, f_sel2); else n_pass++;
        n_total++; if (f_wbwe !== 1'b0 || f_wbrd !== 5'd0) $display("[TB] FAIL reset_f_wb got=%b/%0d exp=0/0", f_wbwe, f_wbrd); else n_pass++;
        n_total++; if (f_scnt !== 4'd0 || f_fcnt !== 4'd0) $display("[TB] FAIL reset_f_cnt got=%0d/%0d exp=0/0", f_scnt, f_fcnt); else n_pass++;
        n_total++; if (n_scnt !== 32'd0 || n_fcnt !== 32'd0 || n_wbwe !== 1'b0) $display("[TB] FAIL reset_n got=%0d/%0d/%b exp=0/0/0", n_scnt, n_fcnt, n_wbwe); else n_pass++;
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_fwd_alu();
        do_reset();
        drive(enc(OP_IMM, 1, 0, 0, 5), 1, 0, 0, 1);
        drive(enc(OP_R, 2, 0, 1, 1), 1, 0, 0, 1);
        n_total++; if (f_stall !== 1'b0) $display("[TB] FAIL fwd_alu_stall got=%b exp=0", f_stall); else n_pass++;
        n_total++; if (f_sel1 !== 2'd1 || f_sel2 !== 2'd1) $display("[TB] FAIL fwd_alu_sel got=%0d/%0d exp=1/1", f_sel1, f_sel2); else n_pass++;
        n_total++; if (n_stall !== 1'b1 || n_sel1 !== 2'd0) $display("[TB] FAIL nofwd_raw got=%b/%0d exp=1/0", n_stall, n_sel1); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(enc(OP_LOAD, 3, 2, 0, 0), 1, 0, 0, 1);
        drive(enc(OP_R, 4, 0, 3, 0), 1, 0, 0, 1);
        n_total++; if (f_stall !== 1'b1) $display("[TB] FAIL load_use_stall got=%b exp=1", f_stall); else n_pass++;
        drive(enc(OP_R, 4, 0, 3, 0), 1, 0, 0, 1);
        n_total++; if (f_stall !== 1'b0 || f_sel1 !== 2'd2) $display("[TB] FAIL load_use_after got=%b/%0d exp=0/2", f_stall, f_sel1); else n_pass++;
        n_total++; if (f_scnt !== 4'd1) $display("[TB] FAIL load_use_cnt got=%0d exp=1", f_scnt); else n_pass++;
    endtask

    task automatic test_nofwd_stall();
        int stalls = 0;
        do_reset();
        drive(enc(OP_IMM, 1, 0, 0, 5), 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            drive(enc(OP_R, 2, 0, 1, 1), 1, 0, 0, 1);
            if (i == 2) begin
                n_total++; if (n_wbwe !== 1'b1 || n_wbrd !== 5'd1) $display("[TB] FAIL nofwd_wb got=%b/%0d exp=1/1", n_wbwe, n_wbrd); else n_pass++;
            end
            if (n_stall !== 1'b1) break;
            stalls++;
        end
        n_total++; if (stalls != 3) $display("[TB] FAIL nofwd_stall_len got=%0d exp=3", stalls); else n_pass++;
        n_total++; if (n_scnt !== 32'd3) $display("[TB] FAIL nofwd_stall_cnt got=%0d exp=3", n_scnt); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        drive(enc(OP_BRANCH, 0, 0, 0, 0), 1, 0, 0, 1);
        drive(enc(OP_JAL, 1, 0, 0, 0), 1, 1, 0, 1);
        n_total++; if (f_bt !== 1'b1 || f_flush !== 1'b1) $display("[TB] FAIL beq_taken got=%b/%b exp=1/1", f_bt, f_flush); else n_pass++;
        n_total++; if (n_bt !== 1'b1 || n_flush !== 1'b1) $display("[TB] FAIL beq_taken_n got=%b/%b exp=1/1", n_bt, n_flush); else n_pass++;
        drive(32'd0, 0, 0, 0, 1);
        n_total++; if (f_flush !== 1'b0) $display("[TB] FAIL flush_bubble got=%b exp=0", f_flush); else n_pass++;
        n_total++; if (f_fcnt !== 4'd1) $display("[TB] FAIL flush_cnt_taken got=%0d exp=1", f_fcnt); else n_pass++;
        drive(enc(OP_BRANCH, 0, 4, 0, 0), 1, 0, 0, 1);
        drive(32'd0, 0, 1, 0, 1);
        n_total++; if (f_bt !== 1'b0 || f_flush !== 1'b0) $display("[TB] FAIL blt_not_taken got=%b/%b exp=0/0", f_bt, f_flush); else n_pass++;
        drive(32'd0, 0, 0, 0, 1);
        n_total++; if (f_fcnt !== 4'd1) $display("[TB] FAIL flush_cnt_hold got=%0d exp=1", f_fcnt); else n_pass++;
    endtask

    task automatic test_freeze();
        do_reset();
        drive(enc(OP_LOAD, 3, 2, 0, 0), 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(enc(OP_R, 4, 0, 3, 0), 1, 0, 0, 0);
            n_total++; if (f_stall !== 1'b1 || f_scnt !== 4'd0) $display("[TB] FAIL freeze_%0d got=%b/%0d exp=1/0", i, f_stall, f_scnt); else n_pass++;
        end
        drive(enc(OP_R, 4, 0, 3, 0), 1, 0, 0, 1);
        n_total++; if (f_stall !== 1'b1) $display("[TB] FAIL freeze_resume got=%b exp=1", f_stall); else n_pass++;
        drive(enc(OP_R, 4, 0, 3, 0), 1, 0, 0, 1);
        n_total++; if (f_stall !== 1'b0 || f_sel1 !== 2'd2 || f_scnt !== 4'd1) $display("[TB] FAIL freeze_after got=%b/%0d/%0d exp=0/2/1", f_stall, f_sel1, f_scnt); else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        drive(enc(OP_IMM, 0, 0, 0, 1), 1, 0, 0, 1);
        drive(enc(OP_R, 5, 0, 0, 0), 1, 0, 0, 1);
        n_total++; if (f_stall !== 1'b0 || f_sel1 !== 2'd0 || n_stall !== 1'b0) $display("[TB] FAIL x0_read got=%b/%0d/%b exp=0/0/0", f_stall, f_sel1, n_stall); else n_pass++;
        drive(32'd0, 0, 0, 0, 1);
        drive(32'd0, 0, 0, 0, 1);
        n_total++; if (f_wbwe !== 1'b0 || n_wbwe !== 1'b0) $display("[TB] FAIL x0_wb_we got=%b/%b exp=0/0", f_wbwe, n_wbwe); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 40; i++) drive(enc(OP_LOAD, 3, 2, 3, 0), 1, 0, 0, 1);
        drive(32'd0, 0, 0, 0, 1);
        n_total++; if (f_scnt !== 4'd15) $display("[TB] FAIL stall_cnt_sat got=%0d exp=15", f_scnt); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(enc(OP_IMM, 1, 0, 0, 5), 1, 0, 0, 1);
        drive(32'd0, 0, 0, 0, 1);
        drive(32'd0, 0, 0, 0, 1);
        @(posedge clk); #2;
        resetn = 0;
        #1;
        n_total++; if (f_wbwe !== 1'b0 || n_wbwe !== 1'b0 || f_wbrd !== 5'd0) $display("[TB] FAIL mid_reset_wb got=%b/%b/%0d exp=0/0/0", f_wbwe, n_wbwe, f_wbrd); else n_pass++;
        model_clear();
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_random();
        logic [6:0] ops [12] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                                 OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYS, OP_BAD};
        logic [31:0] ins;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ins = enc(ops[$urandom_range(0, 11)], $urandom_range(0, 3), $urandom_range(0, 7),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            drive(ins, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
            n_total++; if (f_stall !== e_stall[0]) $display("[TB] FAIL rand_f_stall c=%0d got=%b exp=%b", c, f_stall, e_stall[0]); else n_pass++;
            n_total++; if (f_flush !== e_flush[0] || f_bt !== e_bt[0]) $display("[TB] FAIL rand_f_flush c=%0d got=%b/%b exp=%b/%b", c, f_flush, f_bt, e_flush[0], e_bt[0]); else n_pass++;
            n_total++; if (f_sel1 !== 2'(e_sel1[0]) || f_sel2 !== 2'(e_sel2[0])) $display("[TB] FAIL rand_f_sel c=%0d got=%0d/%0d exp=%0d/%0d", c, f_sel1, f_sel2, e_sel1[0], e_sel2[0]); else n_pass++;
            n_total++; if (f_wbwe !== e_wbwe[0] || (e_wbwe[0] && f_wbrd !== 5'(e_wbrd[0]))) $display("[TB] FAIL rand_f_wb c=%0d got=%b/%0d exp=%b/%0d", c, f_wbwe, f_wbrd, e_wbwe[0], e_wbrd[0]); else n_pass++;
            n_total++; if (f_scnt !== 4'(e_scnt[0]) || f_fcnt !== 4'(e_fcnt[0])) $display("[TB] FAIL rand_f_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, f_scnt, f_fcnt, e_scnt[0], e_fcnt[0]); else n_pass++;
            n_total++; if (n_stall !== e_stall[1]) $display("[TB] FAIL rand_n_stall c=%0d got=%b exp=%b", c, n_stall, e_stall[1]); else n_pass++;
            n_total++; if (n_flush !== e_flush[1] || n_bt !== e_bt[1]) $display("[TB] FAIL rand_n_flush c=%0d got=%b/%b exp=%b/%b", c, n_flush, n_bt, e_flush[1], e_bt[1]); else n_pass++;
            n_total++; if (n_sel1 !== 2'd0 || n_sel2 !== 2'd0) $display("[TB] FAIL rand_n_sel c=%0d got=%0d/%0d exp=0/0", c, n_sel1, n_sel2); else n_pass++;
            n_total++; if (n_wbwe !== e_wbwe[1] || (e_wbwe[1] && n_wbrd !== 5'(e_wbrd[1]))) $display("[TB] FAIL rand_n_wb c=%0d got=%b/%0d exp=%b/%0d", c, n_wbwe, n_wbrd, e_wbwe[1], e_wbrd[1]); else n_pass++;
            n_total++; if (n_scnt !== 32'(e_scnt[1]) || n_fcnt !== 32'(e_fcnt[1])) $display("[TB] FAIL rand_n_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, n_scnt, n_fcnt, e_scnt[1], e_fcnt[1]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_nofwd_stall();
        test_branch();
        test_freeze();
        test_x0();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32i_hazard_unit.md
Name: rv32i_hazard_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the RV32I pipelined core. It sits beside the control path.
- Tracks destination-register tags of every in-flight instruction from EXEC down to WB in a scoreboard shift register.
- Resolves branches and jumps in EXEC; raises stall (optionally only on load-use, when forwarding is enabled) and flush.
- Drives forwarding mux selects for rs1/rs2; keeps saturating stall/flush performance counters.

Parameters:
NB_STAGES, 3, number of tracked stages after DECODE (stage 1 = EXEC, stage NB_STAGES = WB); legal 2..8
FWD_EN, 1, 1 = forwarding datapath present (stall only on load-use); 0 = stall on any RAW match
CNT_W, 32, width of performance counters
SEL_W, $clog2(NB_STAGES+1), width of forwarding selects

Ports:
clk_i  in  1  clock
resetn_i  in  1  asynchronous reset, active-low
imem_valid_i  in  1  1 = pipeline advances this cycle; 0 = scoreboard and counters frozen
dec_instr_i  in  32  instruction currently in DECODE
dec_valid_i  in  1  DECODE slot holds a real instruction
alu_zero_i  in  1  EXEC ALU result == 0
alu_lt_i  in  1  EXEC ALU SLT/SLTU result bit 0
stall_o  out  1  freeze PC and DECODE register, inject bubble into EXEC
flush_o  out  1  kill FETCH and DECODE contents (branch taken or jump in EXEC)
branch_taken_o  out  1  conditional branch in EXEC is taken
fwd_rs1_sel_o  out  SEL_W  0 = register file, k = result of stage k
fwd_rs2_sel_o  out  SEL_W  same for rs2
wb_rd_o  out  5  rd of stage NB_STAGES
wb_we_o  out  1  register-file write enable for stage NB_STAGES
stall_cnt_o  out  CNT_W  cycles with stall_o=1 and imem_valid_i=1, saturating
flush_cnt_o  out  CNT_W  cycles with flush_o=1 and imem_valid_i=1, saturating

Behaviour:
- Decode of dec_instr_i[6:0] (combinational, every flag defaults 0, no latches):
  - R: uses_rs1, uses_rs2, writes_rd.
  - OP-IMM / JALR: uses_rs1, writes_rd.
  - LOAD: uses_rs1, writes_rd, is_load.
  - STORE / BRANCH: uses_rs1, uses_rs2.
  - LUI / AUIPC / JAL: writes_rd.
  - FENCE / SYSTEM / unknown: none.
  - All flags gated by dec_valid_i.
- Scoreboard entry k: {valid, wr, is_load, rd[4:0], opcode[6:0], funct3[2:0]}.
  - Reset: all entries valid=0, remaining fields 0.
  - On clk when imem_valid_i=1: entry k <= entry k-1 for k>=2; entry 1 <= decode record, or a bubble (valid=0) if stall_o|flush_o.
  - When imem_valid_i=0: all entries hold.
- Match(rs, k) = uses_rs & rs!=0 & entry k valid & wr & rd==rs.
- FWD_EN=0:
  - stall_o = match on rs1 or rs2 in any stage 1..NB_STAGES.
  - fwd selects are tied to 0.
- FWD_EN=1:
  - stall_o = match in stage 1 where entry 1 is_load (load-use).
  - fwd_rsX_sel_o = smallest k with Match(rsX,k), else 0; the youngest producer wins.
  - A select of 1 is irrelevant while stalled but still driven.
- branch_taken_o: entry 1 valid and opcode BRANCH, evaluated on funct3:
  - BEQ: zero. BNE: !zero.
  - BLT, BLTU: lt. BGE, BGEU: !lt.
  - Undefined funct3: 0.
- flush_o = branch_taken_o | (entry 1 valid & opcode in {JAL, JALR}).
- Priority: flush_o=1 forces stall_o=0. The instruction in DECODE is on the wrong path and is discarded.
- wb_rd_o = entry NB_STAGES rd; wb_we_o = valid & wr & rd!=0.
- Counters:
  - Reset to 0; increment only when imem_valid_i=1 and the event is active.
  - Saturate at 2^CNT_W-1, no wrap.
- All outputs are combinational from the scoreboard and inputs. At reset: stall_o=0, flush_o=0, branch_taken_o=0, selects 0, wb_we_o=0, wb_rd_o=0, counters 0.
- Reset asserted mid-operation clears all entries immediately; no write-back of in-flight instructions occurs after reset.
- imem_valid_i=0 with a pending hazard: stall_o stays asserted combinationally, no entry moves, counters hold.

Test Plan:
- Reset, then issue addi x1,x0,5 followed by add x2,x1,x1 with FWD_EN=1 -> no stall; fwd_rs1_sel_o=1, fwd_rs2_sel_o=1 in the cycle add is in DECODE.
- lw x3,0(x0) followed by add x4,x3,x0 with FWD_EN=1 -> stall_o=1 for exactly 1 cycle; then fwd_rs1_sel_o=2; stall_cnt_o=1.
- Same add pair with FWD_EN=0, NB_STAGES=3 -> stall_o=1 for 3 consecutive cycles, then proceeds; wb_we_o=1 with wb_rd_o=1 in the stage-3 cycle.
- beq x0,x0 in EXEC with alu_zero_i=1 -> branch_taken_o=1, flush_o=1, EXEC gets a bubble next cycle; blt with alu_lt_i=0 -> no flush; flush_cnt_o increments only on the taken case.
- Hazard in DECODE with imem_valid_i held 0 for 4 cycles -> entries frozen, stall_cnt_o unchanged, stall_o remains 1; resumes normally once imem_valid_i=1.
- Write to x0 (addi x0,x0,1) then read of x0 -> no stall, select 0, wb_we_o=0; counter preloaded near saturation by a long stall stream -> stays at 2^CNT_W-1.
